// File: rtl/noc_axi_pkg.sv
// Types shared by the AXI4-Lite endpoints on the NoC: response codes and
// the channel FSM state encodings.
package noc_axi_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

endpackage

// File: rtl/axi_lite_mem_array.sv
// Word-addressed register file: async active-low clear, byte-enabled
// synchronous write, combinational read.
module axi_lite_mem_array #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [DEPTH-1:0][31:0] mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read sees the pre-write contents on a colliding edge.
  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite target serving one address window from a small register memory.
// Independent write (AW+W -> B) and read (AR -> R) channel FSMs.
module axi_lite_mem_slave
  import noc_axi_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h5000_0000,
  parameter int                    MEM_DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [2:0]              s_awprot,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [2:0]              s_arprot,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  // One extra bit so a window ending at the top of the address space
  // does not wrap.
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH+1)'(4 * MEM_DEPTH);

  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= WIN_LO) && ({1'b0, a} < WIN_HI);
  endfunction

  logic unused_prot;
  assign unused_prot = ^{s_awprot, s_arprot};

  // Keeps all readys low until the first edge after reset release.
  logic rst_done;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_done <= 1'b0;
    else      rst_done <= 1'b1;
  end

  // ---------------- write channel ----------------
  w_state_t w_state, w_next;
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [3:0]            w_strb;
  resp_t                 bresp_q;

  logic                  aw_fire, w_fire, b_fire, wr_commit, wr_hit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [3:0]            wr_strb;

  assign s_awready = rst_done && (w_state == W_IDLE) && !aw_held;
  assign s_wready  = rst_done && (w_state == W_IDLE) && !w_held;
  assign s_bvalid  = (w_state == W_RESP);
  assign s_bresp   = bresp_q;

  assign aw_fire = s_awvalid && s_awready;
  assign w_fire  = s_wvalid && s_wready;
  assign b_fire  = s_bvalid && s_bready;

  // Whichever half arrives on the commit edge is used directly from the bus.
  assign wr_addr   = aw_held ? aw_addr : s_awaddr;
  assign wr_data   = w_held  ? w_data  : s_wdata;
  assign wr_strb   = w_held  ? w_strb  : s_wstrb;
  assign wr_commit = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
  assign wr_hit    = in_window(wr_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) w_state <= W_IDLE;
    else      w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (wr_commit) w_next = W_RESP;
      W_RESP:  if (s_bready)  w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_addr <= s_awaddr;
      end
      if (w_fire) begin
        w_held <= 1'b1;
        w_data <= s_wdata;
        w_strb <= s_wstrb;
      end
      if (wr_commit) bresp_q <= wr_hit ? RESP_OKAY : RESP_DECERR;
      if (b_fire) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t r_state, r_next;
  logic                  ar_fire, r_fire, rd_hit;
  logic [31:0]           mem_rdata;
  logic [DATA_WIDTH-1:0] rdata_q;
  resp_t                 rresp_q;

  assign s_arready = rst_done && (r_state == R_IDLE);
  assign s_rvalid  = (r_state == R_DATA);
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;

  assign ar_fire = s_arvalid && s_arready;
  assign r_fire  = s_rvalid && s_rready;
  assign rd_hit  = in_window(s_araddr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= R_IDLE;
    else      r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_next = R_DATA;
      R_DATA:  if (r_fire)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_fire) begin
      rdata_q <= rd_hit ? mem_rdata : '0;
      rresp_q <= rd_hit ? RESP_OKAY : RESP_DECERR;
    end
  end

  axi_lite_mem_array #(
    .DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_commit && wr_hit),
    .waddr (wr_addr[IDX_W+1:2]),
    .wdata (wr_data),
    .wstrb (wr_strb),
    .raddr (s_araddr[IDX_W+1:2]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Randomized and directed bench for axi_lite_mem_slave against an
// array-based memory model of the address window.
module tb_axi_lite_mem_slave;
  localparam longint unsigned BASE  = 64'h5000_0000;
  localparam int              DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [2:0]  s_awprot, s_arprot;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mdl [DEPTH];

  always #5 clk = ~clk;

  axi_lite_mem_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .BASE_ADDR  (32'h5000_0000),
    .MEM_DEPTH  (DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit mhit(input logic [31:0] a);
    longint unsigned x = {32'h0, a};
    return (x >= BASE) && (x < BASE + 4 * DEPTH);
  endfunction

  function automatic int midx(input logic [31:0] a);
    longint unsigned x = {32'h0, a};
    return int'((x - BASE) / 4);
  endfunction

  function automatic logic [31:0] exp_resp(input logic [31:0] a);
    return mhit(a) ? 32'd0 : 32'd3;
  endfunction

  // Entered and left at #1 after a rising edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_lead, input int b_hold);
    bit aw_hs, w_hs, aw_done, w_done;
    int n;
    logic [1:0] resp0;
    aw_done = 0; w_done = 0; n = 0;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_wvalid = 1'b1; s_awvalid = (w_lead == 0); s_bready = 1'b0;
    while (!(aw_done && w_done)) begin
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      @(posedge clk); #1; n++;
      if (aw_hs) begin aw_done = 1; s_awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  s_wvalid = 1'b0;  end
      if (!aw_done && n >= w_lead) s_awvalid = 1'b1;
      if (w_done && !aw_done) chk("wready_low_while_held", 32'(s_wready), 0);
      if (n > 100) begin chk("write_handshake_timeout", 0, 1); break; end
    end
    chk("bvalid_latency", 32'(s_bvalid), 1);
    resp0 = s_bresp;
    for (int i = 0; i < b_hold; i++) begin
      @(posedge clk); #1;
      chk("bvalid_hold", 32'(s_bvalid), 1);
      chk("bresp_stable", 32'(s_bresp), 32'(resp0));
      chk("awready_low_in_resp", 32'(s_awready), 0);
      chk("wready_low_in_resp", 32'(s_wready), 0);
    end
    chk("bresp", 32'(s_bresp), exp_resp(addr));
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    chk("bvalid_drop", 32'(s_bvalid), 0);
    chk("awready_back", 32'(s_awready), 1);
    chk("wready_back", 32'(s_wready), 1);
    if (mhit(addr))
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl[midx(addr)][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic do_read(input logic [31:0] addr, input int r_hold);
    int n;
    logic [31:0] exp;
    exp = mhit(addr) ? mdl[midx(addr)] : 32'h0;
    n = 0;
    s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b0;
    while (!s_arready) begin
      @(posedge clk); #1; n++;
      if (n > 100) begin chk("read_handshake_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    chk("rvalid_latency", 32'(s_rvalid), 1);
    for (int i = 0; i < r_hold; i++) begin
      @(posedge clk); #1;
      chk("rvalid_hold", 32'(s_rvalid), 1);
      chk("arready_low_in_data", 32'(s_arready), 0);
    end
    chk("rdata", s_rdata, exp);
    chk("rresp", 32'(s_rresp), exp_resp(addr));
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;
    chk("rvalid_drop", 32'(s_rvalid), 0);
    chk("arready_back", 32'(s_arready), 1);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    rst = 1'b0;
    s_awaddr = '0; s_awprot = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    s_bready = 0; s_araddr = '0; s_arprot = '0; s_arvalid = 0; s_rready = 0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;

    #50;
    chk("rst_outputs", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp}, 0);
    chk("rst_rdata", s_rdata, 0);
    #150 rst = 1'b1;
    #1 chk("ready_before_edge", {29'h0, s_awready, s_wready, s_arready}, 0);
    @(posedge clk); #1;
    chk("ready_after_release", {29'h0, s_awready, s_wready, s_arready}, 32'h7);

    // basic write/read-back
    do_write(32'h5000_0000, 32'h1100_0011, 4'hF, 0, 0);
    do_write(32'h5000_0004, 32'h2200_0022, 4'hF, 0, 0);
    do_write(32'h5000_0008, 32'h3300_0033, 4'hF, 0, 0);
    do_read(32'h5000_0000, 0);
    do_read(32'h5000_0004, 0);
    do_read(32'h5000_0008, 0);
    chk("readback_const", s_rdata, 32'h3300_0033);

    // W ahead of AW, B backpressured
    do_write(32'h5000_000C, 32'hCAFE_F00D, 4'hF, 3, 5);
    do_read(32'h5000_000C, 2);

    // partial strobes
    do_write(32'h5000_0010, 32'h1111_1111, 4'hF, 0, 0);
    do_write(32'h5000_0010, 32'hAABB_CCDD, 4'b0101, 1, 0);
    do_read(32'h5000_0010, 0);
    chk("strobe_merge_const", s_rdata, 32'h11BB_11DD);
    do_write(32'h5000_0010, 32'hFFFF_FFFF, 4'h0, 0, 0);
    do_read(32'h5000_0010, 0);

    // window edges and misses
    do_write(32'h5000_003C, 32'h3C3C_3C3C, 4'hF, 0, 0);
    do_read(32'h5000_003C, 0);
    do_write(32'h5000_0040, 32'hDEAD_BEEF, 4'hF, 0, 0);
    do_write(32'h1000_0000, 32'hDEAD_BEEF, 4'hF, 2, 1);
    do_read(32'h5000_0040, 0);
    chk("miss_rresp_const", 32'(s_rresp), 3);
    do_read(32'h1000_0000, 1);
    do_read(32'h5000_0000, 0);

    // same-edge write and read on one word
    s_awaddr = 32'h5000_0008; s_wdata = 32'h3311_1133; s_wstrb = 4'hF;
    s_araddr = 32'h5000_0008;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; s_bready = 0; s_rready = 0;
    @(posedge clk); #1;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    chk("collide_bvalid", 32'(s_bvalid), 1);
    chk("collide_rvalid", 32'(s_rvalid), 1);
    chk("collide_rdata_old", s_rdata, mdl[2]);
    s_bready = 1; s_rready = 1;
    @(posedge clk); #1;
    s_bready = 0; s_rready = 0;
    mdl[2] = 32'h3311_1133;
    do_read(32'h5000_0008, 0);

    // randomized traffic
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 7))
        0:       a = 32'h5000_0040 + 32'($urandom_range(0, 255));
        1:       a = 32'h1000_0000 + 32'($urandom_range(0, 63));
        2:       a = 32'h4FFF_FFFC + 32'($urandom_range(0, 3));
        default: a = 32'h5000_0000 + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
      endcase
      d = $urandom();
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 2));
      else                           do_read(a, $urandom_range(0, 2));
    end

    // reset while a read response is pending
    do_write(32'h5000_0000, 32'h0BAD_0BAD, 4'hF, 0, 0);
    s_araddr = 32'h5000_0000; s_arvalid = 1; s_rready = 0;
    @(posedge clk); #1;
    s_arvalid = 0;
    chk("pre_reset_rvalid", 32'(s_rvalid), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_reset_rvalid", 32'(s_rvalid), 0);
    chk("mid_reset_rdata", s_rdata, 0);
    chk("mid_reset_arready", 32'(s_arready), 0);
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    do_read(32'h5000_0000, 0);
    do_read(32'h5000_0008, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
